// File: rtl/tcm_boot_pkg.sv
// Shared definitions for the TCM boot loader.
//   boot_state_e : boot sequencer FSM states
//   WE_ALL       : full-word TCM byte-enable pattern
//   WORD_BYTES   : byte stride between consecutive instruction words
package tcm_boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        GAP,
        CORE_RST,
        RUN,
        DRAIN,
        DONE
    } boot_state_e;

    localparam logic [3:0]  WE_ALL     = 4'hF;
    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/boot_cycle_cnt.sv
// Loadable saturating up-counter used for the phase timing of the boot loader.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   ld, ld_val : synchronous load, wins over en
//   en         : count up by one, holding at all-ones
//   cnt        : current count
module boot_cycle_cnt #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (ld)
            cnt <= ld_val;
        else if (en && (cnt != {W{1'b1}}))
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/tcm_boot_loader.sv
// Boot sequencer in front of riscv_tcm_top: streams NUM_WORDS instruction
// words into TCM through the tb_inst_* port, pulses the core reset, then
// watches the core PC for END_PC and reports done or timeout.
//
// Ports
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   start_i             start / restart pulse (honoured in IDLE and DONE only)
//   s_valid_i/s_data_i  instruction stream in; s_ready_o high throughout LOAD
//   tb_inst_*_o         registered TCM write port, one write per handshake
//   rst_cpu_o           core reset, high until RUN
//   core_pc_i           core PC monitored during RUN
//   busy_o, done_o, timeout_o, run_cycles_o, checksum_o  status
//
// Build option: LOADER_CHECKSUM_EN adds a wrap-around sum of accepted words
// on checksum_o; without it checksum_o is constant zero.
module tcm_boot_loader
    import tcm_boot_pkg::*;
#(
    parameter int unsigned NUM_WORDS       = 437,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter logic [31:0] END_PC          = 32'h0000_02E0,
    parameter int unsigned DRAIN_CYCLES    = 50,
    parameter int unsigned TIMEOUT_CYCLES  = 40000,
    parameter int unsigned CORE_RST_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        s_valid_i,
    input  logic [31:0] s_data_i,
    output logic        s_ready_o,
    output logic [3:0]  tb_inst_we_o,
    output logic [31:0] tb_inst_addr_o,
    output logic [31:0] tb_inst_data_o,
    output logic        rst_cpu_o,
    input  logic [31:0] core_pc_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        timeout_o,
    output logic [31:0] run_cycles_o,
    output logic [31:0] checksum_o
);

    localparam int unsigned IW         = $clog2(NUM_WORDS + 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_WORDS - 1);
    localparam logic [31:0] CRST_LAST  = 32'(CORE_RST_CYCLES - 1);
    localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_CYCLES - 1);
    localparam logic [31:0] RUN_LAST   = 32'(TIMEOUT_CYCLES - 1);

    boot_state_e   state, state_nxt;
    logic [IW-1:0] idx;
    logic [31:0]   ph_cnt;
    logic          hs, start_ok, pc_hit, run_exp;
    logic          ph_ld, ph_en;

    assign s_ready_o = (state == LOAD);
    assign hs        = s_valid_i & s_ready_o;
    assign start_ok  = start_i & ((state == IDLE) | (state == DONE));
    assign pc_hit    = (core_pc_i == END_PC);
    assign run_exp   = (run_cycles_o == RUN_LAST);
    assign rst_cpu_o = (state == IDLE) | (state == LOAD) | (state == GAP) | (state == CORE_RST);
    assign busy_o    = (state != IDLE) & (state != DONE);

    // One phase counter times both CORE_RST and DRAIN; it is zeroed on the
    // cycle before each phase so the first phase cycle sees 0.
    assign ph_ld = (state == GAP) | ((state == RUN) & pc_hit);
    assign ph_en = (state == CORE_RST) | (state == DRAIN);

    boot_cycle_cnt #(.W(32)) u_ph_cnt (
        .clk    (clk_i),
        .rst_n  (rst_ni),
        .ld     (ph_ld),
        .ld_val ('0),
        .en     (ph_en),
        .cnt    (ph_cnt)
    );

    // RUN counter keeps its value through DRAIN/DONE until the next start.
    boot_cycle_cnt #(.W(32)) u_run_cnt (
        .clk    (clk_i),
        .rst_n  (rst_ni),
        .ld     (start_ok),
        .ld_val ('0),
        .en     (state == RUN),
        .cnt    (run_cycles_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (start_i) state_nxt = LOAD;
            LOAD:     if (hs && (idx == IDX_LAST)) state_nxt = GAP;
            GAP:      state_nxt = CORE_RST;
            CORE_RST: if (ph_cnt == CRST_LAST) state_nxt = RUN;
            // END_PC wins over an expiring budget in the same cycle
            RUN:      if (pc_hit) state_nxt = DRAIN;
                      else if (run_exp) state_nxt = DONE;
            DRAIN:    if (ph_cnt == DRAIN_LAST) state_nxt = DONE;
            DONE:     if (start_i) state_nxt = LOAD;
            default:  state_nxt = IDLE;
        endcase
    end

    // Write port: registered one cycle behind the handshake; addr/data hold
    // between writes so the port only ever shows a completed word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx            <= '0;
            tb_inst_we_o   <= '0;
            tb_inst_addr_o <= '0;
            tb_inst_data_o <= '0;
            done_o         <= 1'b0;
            timeout_o      <= 1'b0;
        end else begin
            tb_inst_we_o <= hs ? WE_ALL : 4'h0;
            if (hs) begin
                tb_inst_addr_o <= BASE_ADDR + 32'(idx) * WORD_BYTES;
                tb_inst_data_o <= s_data_i;
                idx            <= idx + IW'(1);
            end
            if (start_ok) begin
                idx       <= '0;
                done_o    <= 1'b0;
                timeout_o <= 1'b0;
            end
            if ((state == RUN) && !pc_hit && run_exp)
                timeout_o <= 1'b1;
            if ((state == DRAIN) && (ph_cnt == DRAIN_LAST))
                done_o <= 1'b1;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] csum;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            csum <= '0;
        else if (start_ok)
            csum <= '0;
        else if (hs)
            csum <= csum + s_data_i;
    end

    assign checksum_o = csum;
`else
    assign checksum_o = 32'h0;
`endif

endmodule

// File: tb/tb_tcm_boot_loader.sv
module tb_tcm_boot_loader;

    localparam int unsigned NW   = 4;
    localparam int unsigned DRN  = 5;
    localparam int unsigned TMO  = 100;
    localparam int unsigned CRST = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_ready;
    logic [3:0]  we;
    logic [31:0] addr, wdata;
    logic        rst_cpu;
    logic [31:0] core_pc = '0;
    logic        busy, done, tmo;
    logic [31:0] run_cycles, csum;

    tcm_boot_loader #(
        .NUM_WORDS       (NW),
        .BASE_ADDR       (32'h0000_0000),
        .END_PC          (32'h0000_02E0),
        .DRAIN_CYCLES    (DRN),
        .TIMEOUT_CYCLES  (TMO),
        .CORE_RST_CYCLES (CRST)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .s_valid_i      (s_valid),
        .s_data_i       (s_data),
        .s_ready_o      (s_ready),
        .tb_inst_we_o   (we),
        .tb_inst_addr_o (addr),
        .tb_inst_data_o (wdata),
        .rst_cpu_o      (rst_cpu),
        .core_pc_i      (core_pc),
        .busy_o         (busy),
        .done_o         (done),
        .timeout_o      (tmo),
        .run_cycles_o   (run_cycles),
        .checksum_o     (csum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          c;
    } wr_t;
    wr_t wq[$];

    always @(negedge clk)
        if (we != 4'h0) wq.push_back('{addr, wdata, cyc});

    typedef struct {
        logic [31:0] data;
        logic [31:0] exp_addr;
    } vec_t;
    vec_t tbl[8];

    int n_tot = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Presents a word and returns the cycle in which it was accepted.
    task automatic send_word(input logic [31:0] d, output int hc);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && n < 20) begin
            tick();
            n++;
        end
        chk("ready_wait", {31'b0, s_ready}, 32'd1);
        hc = cyc;
        tick();
    endtask

    task automatic wait_run(output int rc);
        int n = 0;
        while (rst_cpu && n < 30) begin
            tick();
            n++;
        end
        chk("run_reached", {31'b0, rst_cpu}, 32'd0);
        rc = cyc;
    endtask

    task automatic chk_writes(input string nm, input int base, input int hs0);
        chk({nm, "_count"}, 32'(wq.size()), 32'(NW));
        for (int i = 0; i < NW && i < wq.size(); i++) begin
            chk({nm, "_addr"}, wq[i].a, tbl[base+i].exp_addr);
            chk({nm, "_data"}, wq[i].d, tbl[base+i].data);
            if (hs0 >= 0) chk({nm, "_cyc"}, 32'(wq[i].c), 32'(hs0 + 1 + i));
        end
    endtask

    initial begin
        int hs[NW];
        int rc, n;
        logic [31:0] exp_c1, exp_c6;

        tbl[0] = '{32'h0000_0013, 32'h0};
        tbl[1] = '{32'h0000_0093, 32'h4};
        tbl[2] = '{32'h0000_0113, 32'h8};
        tbl[3] = '{32'h0000_0193, 32'hC};
        tbl[4] = '{32'hFFFF_FFFF, 32'h0};
        tbl[5] = '{32'h0000_0002, 32'h4};
        tbl[6] = '{32'h0000_0000, 32'h8};
        tbl[7] = '{32'h0000_0000, 32'hC};
`ifdef LOADER_CHECKSUM_EN
        exp_c1 = 32'h0000_034C;
        exp_c6 = 32'h0000_0001;
`else
        exp_c1 = 32'h0;
        exp_c6 = 32'h0;
`endif

        // reset state
        repeat (3) tick();
        chk("rst_ready",   {31'b0, s_ready}, 0);
        chk("rst_we",      {28'b0, we}, 0);
        chk("rst_addr",    addr, 0);
        chk("rst_data",    wdata, 0);
        chk("rst_cpu",     {31'b0, rst_cpu}, 1);
        chk("rst_busy",    {31'b0, busy}, 0);
        chk("rst_done",    {31'b0, done}, 0);
        chk("rst_timeout", {31'b0, tmo}, 0);
        chk("rst_runcyc",  run_cycles, 0);
        chk("rst_csum",    csum, 0);
        rst_n = 1'b1;
        tick();

        // 1: back-to-back stream from table
        pulse_start();
        chk("t1_busy", {31'b0, busy}, 1);
        wq.delete();
        for (int i = 0; i < NW; i++) send_word(tbl[i].data, hs[i]);
        s_valid = 1'b0;
        chk("t1_ready_drop", {31'b0, s_ready}, 0);
        for (int i = 1; i < NW; i++) chk("t1_b2b", 32'(hs[i] - hs[0]), 32'(i));
        wait_run(rc);
        // GAP cycle plus CORE_RST cycles separate the last accept from RUN
        chk("t1_rst_fall", 32'(rc - hs[NW-1]), 32'(2 + CRST));
        chk_writes("t1", 0, hs[0]);
        chk("t1_csum", csum, exp_c1);

        // 3: END_PC in the 10th RUN cycle; start during RUN is ignored
        pulse_start();
        chk("t3_start_ign", {31'b0, rst_cpu}, 0);
        repeat (8) tick();
        core_pc = 32'h0000_02E0;
        tick();
        core_pc = 32'h0000_0100;
        n = 0;
        while (!done && n < 50) begin
            tick();
            n++;
        end
        chk("t3_drain_len", 32'(n), 32'(DRN));
        chk("t3_runcyc",    run_cycles, 32'd10);
        chk("t3_timeout",   {31'b0, tmo}, 0);
        chk("t3_busy",      {31'b0, busy}, 0);
        repeat (3) tick();
        chk("t3_hold_done", {31'b0, done}, 1);
        chk("t3_hold_run",  run_cycles, 32'd10);

        // 2: valid toggling; extra valids after the last accept are dropped
        pulse_start();
        chk("t2_done_clr", {31'b0, done}, 0);
        chk("t2_rst_cpu",  {31'b0, rst_cpu}, 1);
        chk("t2_run_clr",  run_cycles, 0);
        wq.delete();
        for (int k = 0; k < 10; k++) begin
            if (k == 7) chk("t2_ready_drop", {31'b0, s_ready}, 0);
            s_valid = (k % 2 == 0);
            s_data  = 32'hA000 + 32'(k);
            tick();
        end
        s_valid = 1'b0;
        wait_run(rc);
        chk("t2_count", 32'(wq.size()), 32'(NW));
        for (int i = 0; i < NW && i < wq.size(); i++) begin
            chk("t2_addr", wq[i].a, 32'(4 * i));
            chk("t2_data", wq[i].d, 32'hA000 + 32'(2 * i));
        end

        // 4: END_PC never seen -> timeout after TMO RUN cycles
        n = 0;
        while (!tmo && n < 300) begin
            tick();
            n++;
        end
        chk("t4_timeout",  {31'b0, tmo}, 1);
        chk("t4_when",     32'(cyc - rc), 32'(TMO));
        chk("t4_runcyc",   run_cycles, 32'(TMO));
        chk("t4_done",     {31'b0, done}, 0);
        chk("t4_busy",     {31'b0, busy}, 0);

        // 5: asynchronous reset in the middle of LOAD
        pulse_start();
        send_word(32'hDEAD_0000, hs[0]);
        send_word(32'hDEAD_0001, hs[1]);
        rst_n = 1'b0;
        #1;
        chk("t5_we",      {28'b0, we}, 0);
        chk("t5_addr",    addr, 0);
        chk("t5_data",    wdata, 0);
        chk("t5_ready",   {31'b0, s_ready}, 0);
        chk("t5_rst_cpu", {31'b0, rst_cpu}, 1);
        chk("t5_busy",    {31'b0, busy}, 0);
        chk("t5_timeout", {31'b0, tmo}, 0);
        chk("t5_runcyc",  run_cycles, 0);
        chk("t5_csum",    csum, 0);
        s_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // 6: reload from BASE_ADDR; checksum wraps
        pulse_start();
        wq.delete();
        for (int i = 0; i < NW; i++) send_word(tbl[4+i].data, hs[i]);
        s_valid = 1'b0;
        repeat (2) tick();
        chk_writes("t6", 4, hs[0]);
        chk("t6_csum", csum, exp_c6);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
